ocm_param_loader: RTL and testbench
===================================

# ocm_param_loader

Read sequencer between the 64-bit on-chip memory port and the ISI_channel_ocm / noise_128_wrapper / DFE_prl parameter loaders. After a start pulse, it walks the noise-table region and then the channel-tap region of the OCM. Each returned word is presented with a per-target load strobe and an 8-bit location index. When both regions are loaded, it raises datapath_en to release the PRBS/PAM-4 datapath.

## Interface
Parameters:
- ADDR_W, 14, OCM port-2 address width
- DATA_W, 64, OCM port-2 data width
- NOISE_BASE, 'h000, first noise-table address
- NOISE_WORDS, 128, noise words to load (1..256)
- CHAN_BASE, 'h200, first channel-tap address
- CHAN_WORDS, 5, channel/DFE words to load (1..256)
- ADDR_STEP, 4, address increment per word
- RD_LAT, 1, OCM read latency in cycles (address to mem_rdata valid), 1..4

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin load sequence; sampled only in IDLE or DONE
- abort  in  1  synchronous abort; return to IDLE
- host_wr  in  1  host owns port 2 this cycle; stall address issue
- mem_addr  out  ADDR_W  OCM port-2 address
- mem_rdata  in  DATA_W  OCM port-2 read data
- load_data  out  DATA_W  registered word for consumers
- location  out  8  index of load_data within its region
- noise_load  out  1  load_data is a noise-table word
- chan_load  out  1  load_data is a channel/DFE word
- noise_done  out  1  sticky: noise region fully delivered
- chan_done  out  1  sticky: channel region fully delivered
- busy  out  1  high in any state other than IDLE/DONE
- datapath_en  out  1  high in DONE

## Operation
- States: IDLE, NOISE_RD, NOISE_DRAIN, CHAN_RD, CHAN_DRAIN, DONE.
- IDLE → NOISE_RD on start. The address counter loads NOISE_BASE, and noise_done and chan_done clear.
- x_RD: each cycle with !host_wr, drive the current address and push a tag (target, index) into an RD_LAT-deep tag pipe, then add ADDR_STEP. When host_wr is high, nothing is pushed and the address holds.
- x_RD → x_DRAIN in the cycle after the last of x_WORDS addresses is issued.
- Delivery: when a tag exits the pipe, register mem_rdata into load_data and set location = tag index. Pulse noise_load or chan_load for one cycle. Delivery never stalls, including while host_wr is high.
- NOISE_DRAIN → CHAN_RD in the cycle after the last noise word is delivered. At that point noise_done = 1, and the address counter loads CHAN_BASE.
- CHAN_DRAIN → DONE in the cycle after the last channel word is delivered. At that point chan_done = 1.
- DONE: datapath_en = 1. start restarts the sequence: clear the done flags, drop datapath_en, go to NOISE_RD.
- start while busy: ignored.
- abort, from any state: next cycle the state is IDLE, the tag pipe is flushed, no further strobes are produced, and done flags and datapath_en clear. abort wins over a simultaneous start.
- location width rule: the index counts 0..x_WORDS-1 and is truncated to 8 bits. The address wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - mem_addr = NOISE_BASE
  - load_data = 0
  - location = 0
  - all strobes, flags, busy and datapath_en = 0
  - state = IDLE
  - tag pipe empty
- Reset mid-operation aborts immediately and asynchronously. No strobe is produced after rstn falls.
- Start accepted at edge T0:
  - Address k is driven during cycle T0+1+k (no stalls).
  - Its word is presented with a strobe during cycle T0+2+RD_LAT+k.
- Strobes are single-cycle and mutually exclusive. Delivered words are contiguous when there are no stalls.
- noise_done rises in the cycle after the last noise_load. The first CHAN_BASE address is driven in that same cycle.
- busy is combinational from state. All other outputs are registered.

## Test plan
- Reset then start pulse, RD_LAT=1, no stalls:
  - noise_load is high for 128 consecutive cycles with location 0..127.
  - Addresses run 'h000..'h1FC.
  - chan_load is high for 5 cycles with location 0..4 and addresses 'h200..'h210.
  - datapath_en = 1 after chan_done, and each load_data equals the preloaded OCM word.
- host_wr asserted for 3 cycles during NOISE_RD at word 10:
  - mem_addr holds at 'h028.
  - Words 0..9 still deliver.
  - Total noise strobes = 128 with no duplicates or gaps in location.
- abort asserted in cycle 50 of NOISE_RD:
  - IDLE next cycle, no further strobes, noise_done = 0.
  - A subsequent start reloads from location 0.
- start pulsed during CHAN_RD: ignored. The sequence completes identically to the no-stall case.
- rstn dropped in CHAN_DRAIN: all outputs go to reset values within the same cycle. Restart yields the full 133-word sequence.
- RD_LAT=3 with NOISE_WORDS=4, CHAN_WORDS=2:
  - The first strobe comes 5 cycles after the start edge.
  - 4 noise words, then 2 channel words.
  - datapath_en rises the cycle after the last chan_load.

Source files
------------

// File: rtl/ocm_param_loader.sv
// ocm_param_loader: read sequencer from the OCM read port (port 2) to the parameter loaders.
// After start it reads the noise table and then the channel taps. Each returned word is
// registered with a per-target load strobe and a location index. When both regions are
// loaded it raises datapath_en.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   start_i, abort_i   begin sequence (IDLE/DONE only); synchronous abort to IDLE
//   host_wr_i          host owns the OCM port this cycle, so no address is issued
//   mem_addr_o         OCM address; mem_rdata_i returns its word RD_LAT cycles later
//   load_data_o        registered word for consumers, indexed by location_o
//   noise_load_o       one-cycle strobe: load_data_o is a noise-table word
//   chan_load_o        one-cycle strobe: load_data_o is a channel/DFE word
//   noise_done_o       sticky flag: noise region delivered
//   chan_done_o        sticky flag: channel region delivered
//   busy_o             state is not IDLE or DONE
//   datapath_en_o      high in DONE
module ocm_param_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NOISE_BASE  = 'h000,
    parameter int unsigned NOISE_WORDS = 128,
    parameter int unsigned CHAN_BASE   = 'h200,
    parameter int unsigned CHAN_WORDS  = 5,
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              host_wr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [7:0]        location_o,
    output logic              noise_load_o,
    output logic              chan_load_o,
    output logic              noise_done_o,
    output logic              chan_done_o,
    output logic              busy_o,
    output logic              datapath_en_o
);

    localparam logic [ADDR_W-1:0] NoiseBaseA = ADDR_W'(NOISE_BASE);
    localparam logic [ADDR_W-1:0] ChanBaseA  = ADDR_W'(CHAN_BASE);
    localparam logic [ADDR_W-1:0] StepA      = ADDR_W'(ADDR_STEP);
    localparam logic [8:0]        NoiseLast  = 9'(NOISE_WORDS - 1);
    localparam logic [8:0]        ChanLast   = 9'(CHAN_WORDS - 1);
    localparam int unsigned       LastStg    = RD_LAT - 1;

    typedef enum logic [2:0] {
        StIdle, StNoiseRd, StNoiseDrain, StChanRd, StChanDrain, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          cnt_q, cnt_d;            // 9 bits so a 256-word region can be counted
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [7:0]          location_q, location_d;
    logic                noise_load_q, noise_load_d;
    logic                chan_load_q, chan_load_d;
    logic                noise_done_q, noise_done_d;
    logic                chan_done_q, chan_done_d;
    logic                dp_en_q, dp_en_d;
    logic                push, push_chan;

    // Tag pipe: one stage per cycle of OCM read latency; the last stage lines up with mem_rdata_i.
    logic                tag_vld_q  [RD_LAT];
    logic                tag_vld_d  [RD_LAT];
    logic                tag_chan_q [RD_LAT];
    logic                tag_chan_d [RD_LAT];
    logic [7:0]          tag_idx_q  [RD_LAT];
    logic [7:0]          tag_idx_d  [RD_LAT];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            addr_q       <= NoiseBaseA;
            cnt_q        <= '0;
            load_data_q  <= '0;
            location_q   <= '0;
            noise_load_q <= 1'b0;
            chan_load_q  <= 1'b0;
            noise_done_q <= 1'b0;
            chan_done_q  <= 1'b0;
            dp_en_q      <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_chan_q[i] <= 1'b0;
                tag_idx_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            location_q   <= location_d;
            noise_load_q <= noise_load_d;
            chan_load_q  <= chan_load_d;
            noise_done_q <= noise_done_d;
            chan_done_q  <= chan_done_d;
            dp_en_q      <= dp_en_d;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_d[i];
                tag_chan_q[i] <= tag_chan_d[i];
                tag_idx_q[i]  <= tag_idx_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        noise_done_d = noise_done_q;
        chan_done_d  = chan_done_q;
        dp_en_d      = dp_en_q;
        push         = 1'b0;
        push_chan    = 1'b0;

        // Delivery runs every cycle regardless of host_wr_i.
        load_data_d  = load_data_q;
        location_d   = location_q;
        noise_load_d = tag_vld_q[LastStg] && !tag_chan_q[LastStg];
        chan_load_d  = tag_vld_q[LastStg] && tag_chan_q[LastStg];
        if (tag_vld_q[LastStg]) begin
            load_data_d = mem_rdata_i;
            location_d  = tag_idx_q[LastStg];
        end

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d      = StNoiseRd;
                    addr_d       = NoiseBaseA;
                    cnt_d        = '0;
                    noise_done_d = 1'b0;
                    chan_done_d  = 1'b0;
                    dp_en_d      = 1'b0;
                end
            end
            StNoiseRd: begin
                if (!host_wr_i) begin
                    push   = 1'b1;
                    addr_d = addr_q + StepA;
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q == NoiseLast) state_d = StNoiseDrain;
                end
            end
            StNoiseDrain: begin
                // Region boundary is the strobe of the last index, visible this cycle.
                if (noise_load_q && (location_q == NoiseLast[7:0])) begin
                    state_d      = StChanRd;
                    addr_d       = ChanBaseA;
                    cnt_d        = '0;
                    noise_done_d = 1'b1;
                end
            end
            StChanRd: begin
                if (!host_wr_i) begin
                    push      = 1'b1;
                    push_chan = 1'b1;
                    addr_d    = addr_q + StepA;
                    cnt_d     = cnt_q + 9'd1;
                    if (cnt_q == ChanLast) state_d = StChanDrain;
                end
            end
            StChanDrain: begin
                if (chan_load_q && (location_q == ChanLast[7:0])) begin
                    state_d     = StDone;
                    chan_done_d = 1'b1;
                    dp_en_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        tag_vld_d[0]  = push;
        tag_chan_d[0] = push_chan;
        tag_idx_d[0]  = cnt_q[7:0];
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_chan_d[i] = tag_chan_q[i-1];
            tag_idx_d[i]  = tag_idx_q[i-1];
        end

        // Abort overrides everything, including a simultaneous start.
        if (abort_i) begin
            state_d      = StIdle;
            addr_d       = NoiseBaseA;
            cnt_d        = '0;
            noise_load_d = 1'b0;
            chan_load_d  = 1'b0;
            noise_done_d = 1'b0;
            chan_done_d  = 1'b0;
            dp_en_d      = 1'b0;
            for (int i = 0; i < RD_LAT; i++) tag_vld_d[i] = 1'b0;
        end
    end

    assign mem_addr_o    = addr_q;
    assign load_data_o   = load_data_q;
    assign location_o    = location_q;
    assign noise_load_o  = noise_load_q;
    assign chan_load_o   = chan_load_q;
    assign noise_done_o  = noise_done_q;
    assign chan_done_o   = chan_done_q;
    assign datapath_en_o = dp_en_q;
    assign busy_o        = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_ocm_param_loader.sv
// Bench for ocm_param_loader: a default instance (RD_LAT=1, 128+5 words) and a small one
// (RD_LAT=3, 4+2 words). Expected strobe timing, locations and data come from closed-form
// cycle formulas and an in-order delivery scoreboard over a randomly filled OCM image.
module tb_ocm_param_loader;
    localparam int AW = 14;
    localparam int DW = 64;
    localparam int NB = 'h000;
    localparam int CB = 'h200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, start, abort, host_wr, sel;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] a_addr, b_addr, b_ap0, b_ap1;
    logic [DW-1:0] a_rdata, b_rdata, a_ld, b_ld;
    logic [7:0]    a_loc, b_loc;
    logic a_nl, a_cl, a_nd, a_cd, a_busy, a_dpe;
    logic b_nl, b_cl, b_nd, b_cd, b_busy, b_dpe;

    // OCM read port models: RD_LAT=1 and RD_LAT=3.
    always @(posedge clk) a_rdata <= mem[a_addr];
    always @(posedge clk) begin
        b_ap0   <= b_addr;
        b_ap1   <= b_ap0;
        b_rdata <= mem[b_ap1];
    end

    ocm_param_loader u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .start_i(start && !sel), .abort_i(abort && !sel),
        .host_wr_i(host_wr && !sel), .mem_addr_o(a_addr), .mem_rdata_i(a_rdata),
        .load_data_o(a_ld), .location_o(a_loc), .noise_load_o(a_nl), .chan_load_o(a_cl),
        .noise_done_o(a_nd), .chan_done_o(a_cd), .busy_o(a_busy), .datapath_en_o(a_dpe)
    );

    ocm_param_loader #(.NOISE_WORDS(4), .CHAN_WORDS(2), .RD_LAT(3)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .start_i(start && sel), .abort_i(abort && sel),
        .host_wr_i(host_wr && sel), .mem_addr_o(b_addr), .mem_rdata_i(b_rdata),
        .load_data_o(b_ld), .location_o(b_loc), .noise_load_o(b_nl), .chan_load_o(b_cl),
        .noise_done_o(b_nd), .chan_done_o(b_cd), .busy_o(b_busy), .datapath_en_o(b_dpe)
    );

    logic [AW-1:0] v_addr;
    logic [DW-1:0] v_ld;
    logic [7:0]    v_loc;
    logic v_nl, v_cl, v_nd, v_cd, v_busy, v_dpe;
    always_comb begin
        v_addr = sel ? b_addr : a_addr;
        v_ld   = sel ? b_ld   : a_ld;
        v_loc  = sel ? b_loc  : a_loc;
        v_nl   = sel ? b_nl   : a_nl;
        v_cl   = sel ? b_cl   : a_cl;
        v_nd   = sel ? b_nd   : a_nd;
        v_cd   = sel ? b_cd   : a_cd;
        v_busy = sel ? b_busy : a_busy;
        v_dpe  = sel ? b_dpe  : a_dpe;
    end

    int cfg_n, cfg_c, cfg_l;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input bit s);
        sel   = s;
        cfg_n = s ? 4 : 128;
        cfg_c = s ? 2 : 5;
        cfg_l = s ? 3 : 1;
    endtask

    function automatic logic [63:0] exp_word(input int base, input int idx);
        logic [AW-1:0] a;
        a = AW'(base + 4 * idx);
        return mem[a];
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"}, 64'(v_addr), 64'(NB));
        check_eq({tag, "_data"}, v_ld, 64'd0);
        check_eq({tag, "_loc"}, 64'(v_loc), 64'd0);
        check_eq({tag, "_ctl"}, 64'({v_nl, v_cl, v_nd, v_cd, v_busy, v_dpe}), 64'd0);
    endtask

    // Stall-free run checked cycle by cycle against the closed-form schedule. Cycle n counts
    // from the start edge. inject_n pulses start in that cycle; rst_at drops rstn mid-cycle.
    task automatic run_timed(input int inject_n, input int rst_at);
        int ns, cs, last, idx, base;
        bit nl, cl;
        ns   = 2 + cfg_l;
        cs   = 3 + 2 * cfg_l + cfg_n;
        last = cs + cfg_c + 2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= last; n++) begin
            start = (n == inject_n);
            if (n == rst_at) begin
                #2 rstn = 1'b0;
                #1 check_reset_vals("rst_mid");
                start = 1'b0;
                step();
                rstn = 1'b1;
                step();
                return;
            end
            @(negedge clk);
            nl = (n >= ns) && (n < ns + cfg_n);
            cl = (n >= cs) && (n < cs + cfg_c);
            check_eq("strobes", 64'({v_nl, v_cl}), 64'({nl, cl}));
            check_eq("flags", 64'({v_nd, v_cd, v_dpe, v_busy}),
                     64'({n >= ns + cfg_n, n >= cs + cfg_c, n >= cs + cfg_c, n < cs + cfg_c}));
            if (nl || cl) begin
                idx  = nl ? n - ns : n - cs;
                base = nl ? NB : CB;
                check_eq("loc", 64'(v_loc), 64'(idx[7:0]));
                check_eq("data", v_ld, exp_word(base, idx));
            end
            if (n <= cfg_n) check_eq("addr_noise", 64'(v_addr), 64'(AW'(NB + 4 * (n - 1))));
            if (n >= ns + cfg_n && n < ns + cfg_n + cfg_c)
                check_eq("addr_chan", 64'(v_addr), 64'(AW'(CB + 4 * (n - ns - cfg_n))));
            step();
        end
        start = 1'b0;
    endtask

    // In-order scoreboard run. mode 1: host_wr for 3 cycles at noise word 10.
    // mode 2: random host_wr plus random start pulses while busy.
    task automatic run_collect(input int mode);
        int e, n, idx, base;
        bit done, exp_chan;
        e = 0;
        done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (n = 1; n <= 3000 && !done; n++) begin
            host_wr = (mode == 1) ? (n >= 11 && n <= 13) : ($urandom_range(0, 3) == 0);
            start   = (mode == 2) && v_busy && ($urandom_range(0, 15) == 0);
            @(negedge clk);
            if (mode == 1 && n >= 11 && n <= 14) check_eq("stall_hold", 64'(v_addr), 64'h28);
            if (mode == 1 && n == 15) check_eq("stall_next", 64'(v_addr), 64'h2c);
            if (v_nl || v_cl) begin
                exp_chan = (e >= cfg_n);
                idx  = exp_chan ? e - cfg_n : e;
                base = exp_chan ? CB : NB;
                check_eq("seq_kind", 64'({v_nl, v_cl}), 64'({!exp_chan, exp_chan}));
                check_eq("seq_loc", 64'(v_loc), 64'(idx[7:0]));
                check_eq("seq_data", v_ld, exp_word(base, idx));
                e++;
            end
            if (v_dpe) done = 1'b1;
            step();
        end
        host_wr = 1'b0;
        start   = 1'b0;
        check_eq("done_seen", 64'(done), 64'd1);
        check_eq("seq_count", 64'(e), 64'(cfg_n + cfg_c));
    endtask

    task automatic run_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            abort = (n == 50);
            if (n == 49) begin
                @(negedge clk);
                check_eq("pre_abort_nl", 64'(v_nl), 64'd1);
            end
            step();
        end
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_ctl", 64'({v_busy, v_nl, v_cl, v_nd, v_cd, v_dpe}), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            check_eq("abort_quiet", 64'({v_busy, v_nl, v_cl}), 64'd0);
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        host_wr = 1'b0;
        set_sel(1'b0);
        #12;
        check_reset_vals("reset_a");
        set_sel(1'b1);
        #1 check_reset_vals("reset_b");
        set_sel(1'b0);
        step();
        rstn = 1'b1;
        step();

        run_timed(0, 0);                       // plain sequence
        run_collect(1);                        // host_wr stall at word 10
        run_abort();                           // abort mid-noise, then full reload
        run_timed(0, 0);
        run_timed(2 + cfg_l + cfg_n + 1, 0);   // start during CHAN_RD is ignored

        // abort wins over start while in DONE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_vs_start", 64'({v_busy, v_dpe, v_nd, v_cd}), 64'd0);
        step();

        run_timed(0, 136);                     // reset in CHAN_DRAIN
        run_timed(0, 0);
        run_collect(2);

        set_sel(1'b1);
        run_timed(0, 0);
        run_collect(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
